// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, ROM map constants and round functions.
// Used by sha256_rom, sha256_msg_sched and sha256_compress.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IV = 3'd1,
    PRE     = 3'd2,
    ROUND   = 3'd3,
    FINAL   = 3'd4
  } state_t;

  localparam logic [6:0] K_BASE  = 7'd0;
  localparam logic [6:0] IV_BASE = 7'd64;
  localparam int K_ROUNDS = 64;
  localparam int IV_WORDS = 8;

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window.
// w_out is W[t]; each shift appends W[t+16].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] blk_data,
  output logic [31:0]  w_out
);

  logic [31:0] w [16];
  logic [31:0] w_new;

  assign w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  assign w_out = w[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++)
        w[i] <= blk_data[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

endmodule

// File: rtl/sha256_rom.sv
// SHA-256 constant ROM: K[0..63] at 0-63, IV H0..H7 at 64-71.
// Registered read, one cycle latency.
module sha256_rom (
  input  logic        clk,
  input  logic [6:0]  addr,
  output logic [31:0] data
);

  localparam logic [31:0] TBL [72] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2,
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  always_ff @(posedge clk) begin
    if (addr < 7'd72) data <= TBL[addr];
    else              data <= '0;
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 block compression engine fed by sha256_rom.
// Optional debug ports under SHA256_COMPRESS_DBG_EN.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic [6:0]   rom_addr,
  input  logic [31:0]  rom_data,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
`ifdef SHA256_COMPRESS_DBG_EN
  ,
  output logic [2:0]   dbg_state,
  output logic [6:0]   dbg_round
`endif
);

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [31:0] hh [8];
  logic [31:0] v  [8];
  logic [31:0] w_t, t1, t2;
  logic        accept;

  assign blk_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = blk_valid && blk_ready;

`ifdef SHA256_COMPRESS_DBG_EN
  assign dbg_state = state;
  assign dbg_round = (state == ROUND || state == LOAD_IV) ? cnt : 7'd0;
`endif

  sha256_msg_sched u_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state == ROUND),
    .blk_data (blk_data),
    .w_out    (w_t)
  );

  // v[0..7] are working variables a..h
  assign t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6])
            + rom_data + w_t;
  assign t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);

  always_comb begin
    rom_addr = 7'd0;
    unique case (state)
      LOAD_IV:
        if (cnt < 7'(IV_WORDS)) rom_addr = IV_BASE + cnt;
      PRE:
        rom_addr = K_BASE;
      ROUND:
        if (cnt != 7'(K_ROUNDS - 1)) rom_addr = K_BASE + cnt + 7'd1;
      default: rom_addr = 7'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = blk_first ? LOAD_IV : PRE;
      LOAD_IV:
        if (cnt == 7'(IV_WORDS)) state_nxt = PRE;
      PRE:
        state_nxt = ROUND;
      ROUND:
        if (cnt == 7'(K_ROUNDS - 1)) state_nxt = FINAL;
      FINAL:
        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hh[i] <= '0;
        v[i]  <= '0;
      end
    end else begin
      digest_valid <= 1'b0;
      unique case (state)
        IDLE: cnt <= '0;
        LOAD_IV: begin
          // ROM word for H[c-1] arrives one cycle after its address
          if (cnt != 7'd0) hh[3'(cnt - 7'd1)] <= rom_data;
          cnt <= (cnt == 7'(IV_WORDS)) ? 7'd0 : cnt + 7'd1;
        end
        PRE: begin
          for (int i = 0; i < 8; i++) v[i] <= hh[i];
          cnt <= '0;
        end
        ROUND: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          cnt  <= (cnt == 7'(K_ROUNDS - 1)) ? 7'd0 : cnt + 7'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hh[i] <= hh[i] + v[i];
            digest[255 - 32*i -: 32] <= hh[i] + v[i];
          end
          digest_valid <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress with the real sha256_rom.
// Checks ROM contents, FIPS 180-4 digests, latency, back-pressure and reset.
module tb_sha256_compress;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic [6:0]   rom_addr;
  logic [31:0]  rom_data;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
`ifdef SHA256_COMPRESS_DBG_EN
  logic [2:0]   dbg_state;
  logic [6:0]   dbg_round;
`endif

  logic         rom_chk;
  logic [6:0]   chk_addr;
  logic [6:0]   raddr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign raddr = rom_chk ? chk_addr : rom_addr;

  sha256_rom u_rom (
    .clk  (clk),
    .addr (raddr),
    .data (rom_data)
  );

  sha256_compress dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_first    (blk_first),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
`ifdef SHA256_COMPRESS_DBG_EN
    ,
    .dbg_state    (dbg_state),
    .dbg_round    (dbg_round)
`endif
  );

  localparam logic [31:0] KREF [72] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2,
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] BLK_ABC =
    {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY =
    {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  task automatic chk(
    input string tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

`ifdef SHA256_COMPRESS_DBG_EN
  function automatic logic [2:0] exp_state(input int n, input bit f);
    int off;
    off = f ? 9 : 0;
    if (n <= off)           return 3'd1;
    else if (n == off + 1)  return 3'd2;
    else if (n <= off + 65) return 3'd3;
    else if (n == off + 66) return 3'd4;
    else                    return 3'd0;
  endfunction
`endif

  // Offer one block in a ready cycle, then wait for digest_valid.
  // n is the cycle number counted from the accept edge (cycle 0).
  task automatic run(
    input string        tag,
    input logic [511:0] d,
    input bit           f,
    input int           lat,
    input bit           do_dig,
    input logic [255:0] dig,
    input bit           noise
  );
    int n;
    chk({tag, "_ready"}, 256'(blk_ready), 256'(1));
    blk_valid = 1'b1;
    blk_data  = d;
    blk_first = f;
    step;
    n = 1;
    if (!noise) blk_valid = 1'b0;
    while (n <= 200) begin
`ifdef SHA256_COMPRESS_DBG_EN
      chk({tag, "_dbg_state"}, 256'(dbg_state), 256'(exp_state(n, f)));
      if (n == (f ? 74 : 65))
        chk({tag, "_dbg_round63"}, 256'(dbg_round), 256'(63));
`endif
      if (digest_valid) break;
      if (noise) begin
        if (n == 40)
          chk({tag, "_busy_not_ready"}, 256'({busy, blk_ready}), 256'(2'b10));
        blk_data = {16{$urandom()}};
        blk_first = $urandom_range(0, 1) != 0;
      end
      step;
      n++;
    end
    blk_valid = 1'b0;
    chk({tag, "_latency"}, 256'(n), 256'(lat));
    if (do_dig) chk({tag, "_digest"}, digest, dig);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_first = 1'b0;
    rom_chk   = 1'b0;
    chk_addr  = '0;
    repeat (3) step;

    chk("rst_busy",    256'(busy),         256'(0));
    chk("rst_dvalid",  256'(digest_valid), 256'(0));
    chk("rst_digest",  digest,             256'(0));
    chk("rst_romaddr", 256'(rom_addr),     256'(0));
    chk("rst_ready",   256'(blk_ready),    256'(0));
    rst = 1'b0;
    #1;
    chk("idle_ready",  256'(blk_ready),    256'(1));

    rom_chk = 1'b1;
    for (int i = 0; i < 72; i++) begin
      chk_addr = 7'(i);
      step;
      chk($sformatf("rom_%0d", i), 256'(rom_data), 256'(KREF[i]));
    end
    rom_chk = 1'b0;
    step;

    run("abc",   BLK_ABC,   1'b1, 76, 1'b1, DIG_ABC,   1'b0);
    chk("abc_pulse_ready", 256'(blk_ready), 256'(1));
    step;
    chk("abc_pulse_once", 256'(digest_valid), 256'(0));
    chk("abc_digest_hold", digest, DIG_ABC);

    run("empty", BLK_EMPTY, 1'b1, 76, 1'b1, DIG_EMPTY, 1'b0);

    run("two_a", BLK_2A,    1'b1, 76, 1'b0, '0,        1'b0);
    run("two_b", BLK_2B,    1'b0, 67, 1'b1, DIG_2,     1'b0);
    step;

    run("bp_abc", BLK_ABC,  1'b1, 76, 1'b1, DIG_ABC,   1'b1);
    step;
    chk("bp_idle", 256'(busy), 256'(0));

    blk_valid = 1'b1;
    blk_data  = BLK_ABC;
    blk_first = 1'b1;
    step;
    blk_valid = 1'b0;
    n = 1;
    while (n < 41) begin
      step;
      n++;
    end
`ifdef SHA256_COMPRESS_DBG_EN
    chk("mid_dbg_round30", 256'(dbg_round), 256'(30));
`endif
    chk("mid_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    step;
    chk("mrst_busy",    256'(busy),         256'(0));
    chk("mrst_dvalid",  256'(digest_valid), 256'(0));
    chk("mrst_digest",  digest,             256'(0));
    chk("mrst_romaddr", 256'(rom_addr),     256'(0));
    chk("mrst_ready",   256'(blk_ready),    256'(0));
`ifdef SHA256_COMPRESS_DBG_EN
    chk("mrst_dbg", 256'({dbg_state, dbg_round}), 256'(0));
`endif
    rst = 1'b0;
    #1;
    run("post_rst_abc", BLK_ABC, 1'b1, 76, 1'b1, DIG_ABC, 1'b0);
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Round engine that sits directly downstream of `sha256_rom`. It accepts one padded 512-bit message block per handshake and drives the ROM address. It loads the initial hash words from ROM addresses 64–71 when a new message starts, then runs the 64 SHA-256 rounds with K[t] fetched from ROM addresses 0–63. It outputs the updated 256-bit chaining value, which is the digest after the last block.

## Interface
Parameters: none. All widths are fixed by FIPS 180-4.

Clocking and reset: one clock; reset is synchronous and active-high. Ports `clk` and `rst`.

- `clk` in 1 — rising-edge clock, shared with `sha256_rom`.
- `rst` in 1 — synchronous, active-high reset.
- `blk_valid` in 1 — `blk_data` and `blk_first` are valid.
- `blk_ready` out 1 — block can be accepted; equals (state==IDLE) && !rst.
- `blk_data` in 512 — padded block; bits [511:480] = W0, big-endian words.
- `blk_first` in 1 — 1 = first block of a message: reload IV from ROM; 0 = chain from the current H.
- `rom_addr` out 7 — address to `sha256_rom`; combinational from state and counter.
- `rom_data` in 32 — ROM output, valid one cycle after `rom_addr`.
- `digest` out 256 — {H0..H7}, H0 in bits [255:224]; registered.
- `digest_valid` out 1 — one-cycle pulse when `digest` updates.
- `busy` out 1 — state != IDLE.

## Operation
- A block is accepted when `blk_valid` && `blk_ready` on a clock edge. On acceptance:
  - `blk_data` is latched into the 16-word W window.
  - `blk_first` is latched.
- **FSM states:** IDLE, LOAD_IV, PRE, ROUND, FINAL.
- **IDLE**
  - On accept with first=1 → LOAD_IV, counter c=0.
  - On accept with first=0 → PRE.
  - `blk_valid` while not ready is ignored; no queuing.
- **LOAD_IV**, 9 cycles, c=0..8:
  - For c≤7, `rom_addr`=64+c.
  - For c≥1, H[c-1] <= `rom_data`.
  - At c=8 → PRE.
- **PRE**, 1 cycle:
  - `rom_addr`=0.
  - a..h <= H0..H7.
  - Round counter t=0.
  - → ROUND.
- **ROUND**, 64 cycles, t=0..63:
  - `rom_data` is K[t].
  - `rom_addr`=t+1 for t<63, else 0.
  - Standard round: T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t]; T2 = Σ0(a)+Maj(a,b,c).
  - All additions are mod 2^32; carries are discarded.
  - W[t] is window word 0.
  - The window shifts each round, appending σ1(W[t+14])+W[t+9]+σ0(W[t+1])+W[t].
  - At t=63 → FINAL.
- **FINAL**, 1 cycle:
  - H[i] <= H[i]+{a..h}[i], mod 2^32.
  - `digest` <= the new H.
  - `digest_valid` <= 1 on the next cycle.
  - → IDLE.
- `rom_addr`=0 in IDLE and FINAL.
- **Reset values** (applied whatever the current state, including mid-round):
  - state=IDLE, all counters 0.
  - H, a..h, W = 0.
  - `digest`=0, `digest_valid`=0, `busy`=0, `rom_addr`=0.
  - `blk_ready`=0 while `rst` is high.
- A chained block (first=0) accepted after reset hashes from H=0. This is defined behaviour, not an error.

## Timing
- First block: accept at cycle 0; LOAD_IV cycles 1–9; PRE 10; ROUND 11–74; FINAL 75.
  - `digest_valid`=1 and `blk_ready`=1 at cycle 76.
  - Block period is 76 cycles.
- Chained block: PRE 1; ROUND 2–65; FINAL 66.
  - `digest_valid`=1 at cycle 67.
  - Block period is 67 cycles.
- A new block may be accepted in the same cycle as the `digest_valid` pulse.
  - The pulse is not stretched.
  - `digest` holds until the next FINAL.
- ROM read latency is exactly 1 cycle. The address for the next consumed word is always issued one cycle ahead.

## Configuration
- Macro `SHA256_COMPRESS_DBG_EN`.
- **Defined:** adds output ports
  - `dbg_state` [2:0]: IDLE=0, LOAD_IV=1, PRE=2, ROUND=3, FINAL=4.
  - `dbg_round` [6:0]: t during ROUND, c during LOAD_IV, 0 otherwise.
  - Both reset to 0.
- **Undefined:** neither port exists. Functional behaviour and timing are identical either way.

## Structure
- **`sha256_pkg`** holds:
  - The state enum.
  - ROM map constants `K_BASE`=7'd0 and `IV_BASE`=7'd64.
  - `K_ROUNDS`=64 and `IV_WORDS`=8.
  - Functions `ch`, `maj`, `bsig0`, `bsig1`, `ssig0`, `ssig1`.
- **`sha256_msg_sched`** is the natural sub-module:
  - 16×32 shift window.
  - Ports: load, shift, `blk_data`, `w_out`.
- FSM, working variables and H registers stay in `sha256_compress`.
- The bench instantiates the real `sha256_rom`. It first checks ROM words 0–71 against the FIPS 180-4 constants (e.g. word 0 = 32'h428a2f98, word 64 = 32'h6a09e667).

## Test plan
- **"abc" block, first=1:**
  - Block is 61626380, 13 zero words, final word 00000018.
  - Requires `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - `digest_valid` must pulse exactly 76 cycles after accept.
- **Empty message, first=1:**
  - Block is 80000000 followed by zeros.
  - Requires `digest`=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **Two-block 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":**
  - Block 1 with first=1, block 2 with first=0, block 2 accepted in the `digest_valid` cycle of block 1.
  - Final digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - Block 2 latency is 67 cycles.
- **Back-pressure:**
  - Hold `blk_valid`=1 with changing `blk_data` during busy.
  - No acceptance while busy; only the word present at the IDLE edge is hashed.
  - The "abc" result is unchanged.
- **Reset at round t=30:**
  - Next cycle: all outputs at reset values.
  - A following "abc" first block yields the correct digest in 76 cycles.
- **`SHA256_COMPRESS_DBG_EN` build:**
  - `dbg_state` sequence is 0,1×9,2,3×64,4,0.
  - `dbg_round` reads 63 in the last ROUND cycle.
